// File: rtl/rot_buffer_scheduler.sv
// rtl/rot_buffer_scheduler.sv - voxel write / display read / flush scheduler for a rotating frame buffer
//
// Serialises three kinds of frame-buffer traffic onto one buffer port:
//   - display reads  (disp_req)    : highest priority, one pending slot
//   - buffer flushes (frame_start) : one pending slot, coalesced
//   - voxel writes   (wr_valid)    : FIFO_DEPTH-entry queue, issued in order
// All buffer operations wait for buf_busy=0 in IDLE. Once started, an
// operation always runs to completion. Later requests are recorded and
// handled at the next IDLE.
//
// Ports
//   clk_in, rst_in          clock (rising edge), async active-high reset
//   frame_start             pulse, request a flush
//   wr_valid / wr_ready     voxel write handshake (wr_ready = queue not full)
//   wr_radius/theta/z       voxel coordinates for the write
//   disp_req / disp_theta   display read request and angle
//   disp_valid              pulse in the last READ cycle
//   buf_busy                frame buffer busy
//   buf_flush               flush strobe, asserted in the IDLE cycle that starts a flush
//   buf_new_data            write strobe, asserted in the IDLE cycle that starts a write
//   buf_radius/theta_write/z  write coordinates, valid with buf_new_data
//   buf_theta_read          registered read angle, loaded on READ entry
//   frame_ready             pulse when a flush completes
//   fifo_count              number of queued writes
module rot_buffer_scheduler #(
  parameter int ROTATIONAL_RES = 1024,
  parameter int DISPLAY_RADIUS = 32,
  parameter int DISPLAY_HEIGHT = 64,
  parameter int FIFO_DEPTH     = 8,
  localparam int TW = $clog2(ROTATIONAL_RES),
  localparam int RW = $clog2(DISPLAY_RADIUS),
  localparam int ZW = $clog2(DISPLAY_HEIGHT),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          frame_start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_radius,
  input  logic [TW-1:0] wr_theta,
  input  logic [ZW-1:0] wr_z,
  input  logic          disp_req,
  input  logic [TW-1:0] disp_theta,
  output logic          disp_valid,
  input  logic          buf_busy,
  output logic          buf_flush,
  output logic          buf_new_data,
  output logic [RW-1:0] buf_radius,
  output logic [TW-1:0] buf_theta_write,
  output logic [ZW-1:0] buf_z,
  output logic [TW-1:0] buf_theta_read,
  output logic          frame_ready,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = CW - 1;
  localparam int EW = RW + TW + ZW;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH_ARM,
    S_FLUSH_WAIT,
    S_WRITE_ARM,
    S_WRITE_WAIT,
    S_WRITE_GUARD
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    rd_cnt_q, rd_cnt_d;
  logic          rd_pending_q, rd_pending_d;
  logic [TW-1:0] rd_theta_q, rd_theta_d;
  logic          flush_pending_q, flush_pending_d;
  logic [TW-1:0] theta_read_q, theta_read_d;
  logic          ready_en_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] last_entry_q, last_entry_d;
  logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];

  logic          start_read;
  logic          start_flush;
  logic          start_write;
  logic          disp_valid_c;
  logic          frame_ready_c;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [EW-1:0] out_entry;

  // wr_ready is held low until the first clock after reset release.
  assign wr_ready = ready_en_q && (count_q != FULL_COUNT);
  assign push     = wr_valid && wr_ready;
  assign pop      = start_write;
  assign head     = fifo_mem_q[rd_ptr_q];

  // FSM: next state and strobes
  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    start_read    = 1'b0;
    start_flush   = 1'b0;
    start_write   = 1'b0;
    disp_valid_c  = 1'b0;
    frame_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Nothing starts while the buffer is busy. A pending read also
        // blocks lower-priority work while it waits.
        if (!buf_busy) begin
          if (rd_pending_q) begin
            start_read = 1'b1;
            rd_cnt_d   = 2'd0;
            state_d    = S_READ;
          end else if (flush_pending_q) begin
            start_flush = 1'b1;
            state_d     = S_FLUSH_ARM;
          end else if (count_q != '0) begin
            start_write = 1'b1;
            state_d     = S_WRITE_ARM;
          end
        end
      end
      S_READ: begin
        if (rd_cnt_q == 2'd2) begin
          disp_valid_c = 1'b1;
          state_d      = S_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end
      S_FLUSH_ARM: state_d = S_FLUSH_WAIT;
      S_FLUSH_WAIT: begin
        if (!buf_busy) begin
          frame_ready_c = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_WRITE_ARM: state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: begin
        if (!buf_busy) state_d = S_WRITE_GUARD;
      end
      // One extra cycle so the buffer's registered write enable settles.
      S_WRITE_GUARD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pending requests, read angle, FIFO bookkeeping
  always_comb begin
    // A new request in the same cycle as its service stays pending.
    rd_pending_d    = disp_req || (rd_pending_q && !start_read);
    rd_theta_d      = disp_req ? disp_theta : rd_theta_q;
    flush_pending_d = frame_start || (flush_pending_q && !start_flush);
    theta_read_d    = start_read ? rd_theta_q : theta_read_q;
    wr_ptr_d        = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d        = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    last_entry_d    = pop ? head : last_entry_q;
    count_d         = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q         <= S_IDLE;
      rd_cnt_q        <= 2'd0;
      rd_pending_q    <= 1'b0;
      rd_theta_q      <= '0;
      flush_pending_q <= 1'b0;
      theta_read_q    <= '0;
      ready_en_q      <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      last_entry_q    <= '0;
    end else begin
      state_q         <= state_d;
      rd_cnt_q        <= rd_cnt_d;
      rd_pending_q    <= rd_pending_d;
      rd_theta_q      <= rd_theta_d;
      flush_pending_q <= flush_pending_d;
      theta_read_q    <= theta_read_d;
      ready_en_q      <= 1'b1;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      last_entry_q    <= last_entry_d;
    end
  end

  // Queue storage is not reset. Entries are only read while count_q covers them.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {wr_radius, wr_theta, wr_z};
  end

  // The FIFO head appears on the write bus in the strobe cycle. The bus then
  // holds the last issued entry, which is zero after reset.
  assign out_entry       = start_write ? head : last_entry_q;
  assign buf_radius      = out_entry[EW-1 -: RW];
  assign buf_theta_write = out_entry[ZW +: TW];
  assign buf_z           = out_entry[ZW-1:0];

  assign buf_new_data   = start_write;
  assign buf_flush      = start_flush;
  assign disp_valid     = disp_valid_c;
  assign frame_ready    = frame_ready_c;
  assign buf_theta_read = theta_read_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_rot_buffer_scheduler.sv
// tb/tb_rot_buffer_scheduler.sv - self-checking bench for rot_buffer_scheduler
module tb_rot_buffer_scheduler;

  localparam int TW = 10;
  localparam int RW = 5;
  localparam int ZW = 6;
  localparam int FD = 8;
  localparam int CW = 4;

  logic          clk_in;
  logic          rst_in;
  logic          frame_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [RW-1:0] wr_radius;
  logic [TW-1:0] wr_theta;
  logic [ZW-1:0] wr_z;
  logic          disp_req;
  logic [TW-1:0] disp_theta;
  logic          disp_valid;
  logic          buf_busy;
  logic          buf_flush;
  logic          buf_new_data;
  logic [RW-1:0] buf_radius;
  logic [TW-1:0] buf_theta_write;
  logic [ZW-1:0] buf_z;
  logic [TW-1:0] buf_theta_read;
  logic          frame_ready;
  logic [CW-1:0] fifo_count;

  rot_buffer_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_radius(wr_radius),
    .wr_theta(wr_theta), .wr_z(wr_z), .disp_req(disp_req),
    .disp_theta(disp_theta), .disp_valid(disp_valid), .buf_busy(buf_busy),
    .buf_flush(buf_flush), .buf_new_data(buf_new_data), .buf_radius(buf_radius),
    .buf_theta_write(buf_theta_write), .buf_z(buf_z),
    .buf_theta_read(buf_theta_read), .frame_ready(frame_ready),
    .fifo_count(fifo_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct { int r; int t; int z; } wr_t;
  typedef struct { int kind; int r; int t; int z; int busy; int exp_lat; int exp_a; int exp_b; int exp_c; } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model: accepted-write queue, pending flags, outstanding flush
  wr_t q[$];
  bit  m_rdp, m_flp, m_infl, m_en;
  int  m_rth;
  int  cnum;
  bit  hist_p [8192];
  int  hist_t [8192];
  bit  hist_r [8192];

  // Frame-buffer emulation
  int busy_left, busy_len;
  bit force_busy, rand_busy;

  // Observations from the last cycle
  bit saw_nd, saw_fl, saw_dv, saw_fr;
  int saw_r, saw_t, saw_z, saw_tr, saw_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_rdp = 0; m_flp = 0; m_infl = 0; m_en = 0; m_rth = 0;
    busy_left = 0;
  endtask

  // One clock cycle: drive busy, sample and check mid-cycle, then clock
  // and advance the model.
  task automatic cyc();
    bit nd, fl, dv, fr, req, fs, push;
    int th, s;
    wr_t e;
    buf_busy = force_busy || (busy_left > 0) || (rand_busy && ($urandom_range(0, 3) == 0));
    #1;
    nd = buf_new_data; fl = buf_flush; dv = disp_valid; fr = frame_ready;
    saw_nd = nd; saw_fl = fl; saw_dv = dv; saw_fr = fr;
    saw_r = int'(buf_radius); saw_t = int'(buf_theta_write); saw_z = int'(buf_z);
    saw_tr = int'(buf_theta_read); saw_cnt = int'(fifo_count);
    if (!rst_in) begin
      hist_p[cnum & 8191] = m_rdp;
      hist_t[cnum & 8191] = m_rth;
      hist_r[cnum & 8191] = disp_req;
      chk("fifo_count", int'(fifo_count), q.size());
      chk("wr_ready", int'(wr_ready), (m_en && q.size() < FD) ? 1 : 0);
      chk("strobe_excl", int'(fl && nd), 0);
      if (nd) begin
        chk("wr_nonempty", (q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
          chk("wr_radius", saw_r, q[0].r);
          chk("wr_theta", saw_t, q[0].t);
          chk("wr_z", saw_z, q[0].z);
        end
        chk("wr_priority", int'(m_rdp || m_flp || buf_busy), 0);
      end
      if (fl) chk("flush_priority", int'({m_flp, m_rdp, buf_busy}), 4);
      if (fr) chk("frame_ready_ok", int'({m_infl, buf_busy}), 2);
      if (dv && cnum >= 3) begin
        s = cnum - 3;
        chk("read_pending", int'(hist_p[s & 8191]), 1);
        chk("read_theta", saw_tr, hist_t[s & 8191]);
        m_rdp = 0;
        for (int k = s; k < cnum; k++) if (hist_r[k & 8191]) m_rdp = 1;
      end
    end
    push = wr_valid && m_en && (q.size() < FD) && !rst_in;
    e.r = int'(wr_radius); e.t = int'(wr_theta); e.z = int'(wr_z);
    req = disp_req; th = int'(disp_theta); fs = frame_start;
    @(posedge clk_in);
    #1;
    cnum++;
    if (!rst_in) begin
      if (nd && q.size() > 0) void'(q.pop_front());
      if (push) q.push_back(e);
      if (req) begin m_rdp = 1; m_rth = th; end
      if (fl) m_flp = 0;
      if (fs) m_flp = 1;
      if (fl) m_infl = 1;
      if (fr) m_infl = 0;
      m_en = 1;
    end
    if (nd || fl) busy_left = rand_busy ? $urandom_range(0, 3) : busy_len;
    else if (busy_left > 0) busy_left--;
    wr_valid = 0; disp_req = 0; frame_start = 0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_wr_ready"}, int'(wr_ready), 0);
    chk({pfx, "_fifo_count"}, int'(fifo_count), 0);
    chk({pfx, "_buf_flush"}, int'(buf_flush), 0);
    chk({pfx, "_buf_new_data"}, int'(buf_new_data), 0);
    chk({pfx, "_disp_valid"}, int'(disp_valid), 0);
    chk({pfx, "_frame_ready"}, int'(frame_ready), 0);
    chk({pfx, "_theta_read"}, int'(buf_theta_read), 0);
    chk({pfx, "_coords"}, int'({buf_radius, buf_theta_write, buf_z}), 0);
  endtask

  task automatic set_wr(input int r, input int t, input int z);
    wr_valid = 1; wr_radius = RW'(r); wr_theta = TW'(t); wr_z = ZW'(z);
  endtask

  vec_t vec [9];
  wr_t  got[$];
  int   lat, found, n_ev, dv_at, fl_at, fr_at, tr_at, n_bad;

  initial begin
    rst_in = 1; frame_start = 0; wr_valid = 0; wr_radius = 0; wr_theta = 0; wr_z = 0;
    disp_req = 0; disp_theta = 0; buf_busy = 0;
    force_busy = 0; rand_busy = 0; busy_len = 0; cnum = 0;
    model_reset();

    // kind 0 = write, 1 = read, 2 = flush; exp_a/b/c = expected radius/theta/z or theta_read
    vec[0] = '{0, 5, 700, 12, 2, 1, 5, 700, 12};
    vec[1] = '{1, 0, 300, 0, 0, 4, 0, 300, 0};
    vec[2] = '{1, 0, 1023, 0, 0, 4, 0, 1023, 0};
    vec[3] = '{1, 0, 0, 0, 0, 4, 0, 0, 0};
    vec[4] = '{2, 0, 0, 0, 0, 3, 0, 0, 0};
    vec[5] = '{2, 0, 0, 0, 2, 4, 0, 0, 0};
    vec[6] = '{2, 0, 0, 0, 5, 7, 0, 0, 0};
    vec[7] = '{0, 31, 1023, 63, 0, 1, 31, 1023, 63};
    vec[8] = '{0, 0, 0, 0, 3, 1, 0, 0, 0};

    repeat (2) @(posedge clk_in);
    #1;
    check_zero("reset");
    rst_in = 0;
    repeat (3) cyc();

    for (int i = 0; i < 9; i++) begin
      busy_len = vec[i].busy;
      case (vec[i].kind)
        0: set_wr(vec[i].r, vec[i].t, vec[i].z);
        1: begin disp_req = 1; disp_theta = TW'(vec[i].t); end
        default: frame_start = 1;
      endcase
      cyc();
      found = 0; lat = 0;
      for (int k = 1; k <= 30 && found == 0; k++) begin
        cyc();
        if ((vec[i].kind == 0 && saw_nd) || (vec[i].kind == 1 && saw_dv) || (vec[i].kind == 2 && saw_fr)) begin
          found = 1; lat = k;
        end
      end
      chk($sformatf("vec%0d_latency", i), lat, vec[i].exp_lat);
      if (vec[i].kind == 0) begin
        chk($sformatf("vec%0d_radius", i), saw_r, vec[i].exp_a);
        chk($sformatf("vec%0d_theta", i), saw_t, vec[i].exp_b);
        chk($sformatf("vec%0d_z", i), saw_z, vec[i].exp_c);
        chk($sformatf("vec%0d_count_at_strobe", i), saw_cnt, 1);
      end else if (vec[i].kind == 1) begin
        chk($sformatf("vec%0d_theta_read", i), saw_tr, vec[i].exp_b);
      end
      repeat (12) cyc();
    end

    // Nine back-to-back pushes with the buffer held busy
    force_busy = 1; busy_len = 1;
    for (int i = 0; i < 9; i++) begin
      set_wr(i + 1, 100 * i + 3, 2 * i + 1);
      cyc();
    end
    chk("full_count", int'(fifo_count), 8);
    chk("full_wr_ready", int'(wr_ready), 0);
    force_busy = 0;
    got.delete();
    for (int k = 0; k < 100; k++) begin
      cyc();
      if (saw_nd) got.push_back('{saw_r, saw_t, saw_z});
    end
    chk("burst_nwrites", got.size(), 8);
    n_bad = 0;
    for (int i = 0; i < 8 && i < got.size(); i++)
      if (got[i].r != i + 1 || got[i].t != 100 * i + 3 || got[i].z != 2 * i + 1) n_bad++;
    chk("burst_order", n_bad, 0);

    // Flush and read requested in the same cycle: the read goes first
    busy_len = 2;
    frame_start = 1; disp_req = 1; disp_theta = TW'(300);
    cyc();
    dv_at = -1; fl_at = -1; fr_at = -1; tr_at = -1;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (saw_dv && dv_at < 0) begin dv_at = k; tr_at = saw_tr; end
      if (saw_fl && fl_at < 0) fl_at = k;
      if (saw_fr && fr_at < 0) fr_at = k;
    end
    chk("rf_dv_cycle", dv_at, 4);
    chk("rf_theta_read", tr_at, 300);
    chk("rf_flush_cycle", fl_at, 5);
    chk("rf_frame_ready_cycle", fr_at, 8);

    // Two display requests during WRITE_WAIT collapse into one read
    busy_len = 6;
    set_wr(7, 7, 7);
    n_ev = 0; dv_at = -1; tr_at = -1;
    for (int k = 0; k < 30; k++) begin
      if (k == 4) begin disp_req = 1; disp_theta = TW'(100); end
      if (k == 5) begin disp_req = 1; disp_theta = TW'(900); end
      cyc();
      if (saw_dv) begin n_ev++; dv_at = k; tr_at = saw_tr; end
    end
    chk("dbl_read_count", n_ev, 1);
    chk("dbl_read_theta", tr_at, 900);
    chk("dbl_read_cycle", dv_at, 13);

    // Theta wrap: 1023 then 0 pass through unchanged and in order
    busy_len = 0;
    set_wr(1, 1023, 2); cyc();
    set_wr(3, 0, 4);
    got.delete();
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (saw_nd) got.push_back('{saw_r, saw_t, saw_z});
    end
    chk("wrap_nwrites", got.size(), 2);
    if (got.size() == 2) begin
      chk("wrap_first_theta", got[0].t, 1023);
      chk("wrap_second_theta", got[1].t, 0);
      chk("wrap_second_radius", got[1].r, 3);
    end

    // Reset during FLUSH_WAIT with three queued writes
    busy_len = 0;
    frame_start = 1; set_wr(9, 11, 13); cyc();
    set_wr(10, 12, 14); cyc();
    chk("rst_flush_started", int'(saw_fl), 1);
    force_busy = 1;
    set_wr(11, 13, 15); cyc();
    repeat (3) cyc();
    chk("rst_pre_count", int'(fifo_count), 3);
    #2;
    rst_in = 1;
    #1;
    check_zero("async_reset");
    model_reset();
    force_busy = 0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 0;
    n_ev = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (saw_nd || saw_fl || saw_fr || saw_dv) n_ev++;
    end
    chk("post_reset_strobes", n_ev, 0);

    // Random traffic against the model
    rand_busy = 1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 1) == 1) set_wr($urandom_range(0, 31), $urandom_range(0, 1023), $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) begin disp_req = 1; disp_theta = TW'($urandom_range(0, 1023)); end
      if ($urandom_range(0, 15) == 0) frame_start = 1;
      cyc();
    end
    rand_busy = 0; busy_len = 0;
    repeat (200) cyc();
    chk("drain_fifo_count", int'(fifo_count), 0);
    chk("drain_read_served", int'(m_rdp), 0);
    chk("drain_flush_served", int'(m_flp || m_infl), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
